// File: rtl/sync_counter_pkg.sv
// Shared constants for the synchronous up/down counter: count direction
// encodings and the limit-handling mode encodings used by the step logic.
package sync_counter_pkg;

  // Direction_i encodings
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Limit-handling modes: wrap around the range, or clamp at the limit
  localparam logic MODE_WRAP     = 1'b0;
  localparam logic MODE_SATURATE = 1'b1;

  // Map the integer SATURATE parameter onto a mode encoding
  function automatic logic mode_from_param(input int saturate);
    if (saturate != 32'sd0) begin
      return MODE_SATURATE;
    end else begin
      return MODE_WRAP;
    end
  endfunction

endpackage : sync_counter_pkg

// File: rtl/counter_step.sv
// Combinational next-value generator for the up/down counter. Produces the
// stepped value and flags a limit event: a wrap in wrap mode, or a clamp
// in saturate mode. Both events happen at the same limit points (all-ones
// going up, zero going down); only the resulting value differs.
module counter_step
  import sync_counter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             direction,
  input  logic             mode,
  output logic [WIDTH-1:0] next_value,
  output logic             limit_event
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] stepped_s;
  logic             at_limit_s;

  // Raw +1/-1 result (naturally wraps) and detection of the limit point
  always_comb begin
    stepped_s  = value;
    at_limit_s = 1'b0;
    if (direction == DIR_UP) begin
      stepped_s  = value + ONE;
      at_limit_s = (value == ALL_ONES);
    end else begin
      stepped_s  = value - ONE;
      at_limit_s = (value == ALL_ZERO);
    end
  end

  // In saturate mode a step at the limit leaves the value untouched
  always_comb begin
    next_value  = stepped_s;
    limit_event = at_limit_s;
    if (at_limit_s && (mode == MODE_SATURATE)) begin
      next_value = value;
    end else begin
      next_value = stepped_s;
    end
  end

endmodule : counter_step

// File: rtl/sync_updown_counter.sv
// Synchronous up/down counter with preset, wrap or saturate limit handling,
// a one-cycle limit-event flag, and combinational match/zero compares.
// ARST is a synchronous active-low reset sampled only on rising CLK.
module sync_updown_counter
  import sync_counter_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int               SATURATE    = 0
) (
  input  logic             CLK,
  input  logic             ARST,
  input  logic             Enable_i,
  input  logic             Direction_i,
  input  logic             Preset_i,
  input  logic [WIDTH-1:0] PresetVal_i,
  input  logic [WIDTH-1:0] CompareVal_i,
  output logic [WIDTH-1:0] D_o,
  output logic             Overflow_o,
  output logic             Match_o,
  output logic             Zero_o
);

  localparam logic MODE = mode_from_param(SATURATE);

  logic [WIDTH-1:0] d_r;
  logic             ovf_r;
  logic [WIDTH-1:0] step_value_s;
  logic             step_event_s;
  logic [WIDTH-1:0] d_next_s;
  logic             ovf_next_s;

  counter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .value       (d_r),
    .direction   (Direction_i),
    .mode        (MODE),
    .next_value  (step_value_s),
    .limit_event (step_event_s)
  );

  // Priority mux: preset beats enable beats hold; the flag only follows a step
  always_comb begin
    d_next_s   = d_r;
    ovf_next_s = 1'b0;
    if (Preset_i) begin
      d_next_s   = PresetVal_i;
      ovf_next_s = 1'b0;
    end else if (Enable_i) begin
      d_next_s   = step_value_s;
      ovf_next_s = step_event_s;
    end else begin
      d_next_s   = d_r;
      ovf_next_s = 1'b0;
    end
  end

  // Counter and flag registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!ARST) begin
      d_r   <= RESET_VALUE;
      ovf_r <= 1'b0;
    end else begin
      d_r   <= d_next_s;
      ovf_r <= ovf_next_s;
    end
  end

  // Outputs: registered value and flag, combinational comparators
  always_comb begin
    D_o        = d_r;
    Overflow_o = ovf_r;
    Match_o    = (d_r == CompareVal_i);
    Zero_o     = (d_r == {WIDTH{1'b0}});
  end

endmodule : sync_updown_counter

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench: one wrap-mode and one saturate-mode instance driven
// by the same stimulus; expected results are pushed to a queue per step
// and popped after the clock edge for comparison.
module tb_sync_updown_counter;

  localparam int         W     = 8;
  localparam logic [7:0] RV_W  = 8'h00;
  localparam logic [7:0] RV_S  = 8'h5A;

  logic       clk;
  logic       arst;
  logic       en;
  logic       dir;
  logic       pre;
  logic [7:0] pval;
  logic [7:0] cmp;

  logic [7:0] d_w, d_s;
  logic       ovf_w, ovf_s, match_w, match_s, zero_w, zero_s;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] d_w;
    logic       o_w;
    logic [7:0] d_s;
    logic       o_s;
    logic [7:0] cmp;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] m_dw, m_ds;
  logic       m_ow, m_os;

  sync_updown_counter #(.WIDTH(W), .RESET_VALUE(RV_W), .SATURATE(0)) u_wrap (
    .CLK(clk), .ARST(arst), .Enable_i(en), .Direction_i(dir), .Preset_i(pre),
    .PresetVal_i(pval), .CompareVal_i(cmp), .D_o(d_w), .Overflow_o(ovf_w),
    .Match_o(match_w), .Zero_o(zero_w)
  );

  sync_updown_counter #(.WIDTH(W), .RESET_VALUE(RV_S), .SATURATE(1)) u_sat (
    .CLK(clk), .ARST(arst), .Enable_i(en), .Direction_i(dir), .Preset_i(pre),
    .PresetVal_i(pval), .CompareVal_i(cmp), .D_o(d_s), .Overflow_o(ovf_s),
    .Match_o(match_s), .Zero_o(zero_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one counter for one clock edge
  task automatic model(input logic sat, input logic [7:0] rv,
                       inout logic [7:0] d, inout logic o);
    if (!arst) begin
      d = rv; o = 1'b0;
    end else if (pre) begin
      d = pval; o = 1'b0;
    end else if (en) begin
      if (dir) begin
        if (d == 8'hFF) begin o = 1'b1; d = sat ? 8'hFF : 8'h00; end
        else begin o = 1'b0; d = d + 8'h01; end
      end else begin
        if (d == 8'h00) begin o = 1'b1; d = sat ? 8'h00 : 8'hFF; end
        else begin o = 1'b0; d = d - 8'h01; end
      end
    end else begin
      o = 1'b0;
    end
  endtask

  task automatic step(input logic a, input logic e, input logic dr, input logic p,
                      input logic [7:0] pv, input logic [7:0] cv);
    exp_t x;
    @(negedge clk);
    arst = a; en = e; dir = dr; pre = p; pval = pv; cmp = cv;
    model(1'b0, RV_W, m_dw, m_ow);
    model(1'b1, RV_S, m_ds, m_os);
    x.d_w = m_dw; x.o_w = m_ow; x.d_s = m_ds; x.o_s = m_os; x.cmp = cv;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check_eq("wrap_d",     d_w,     x.d_w);
    check_eq("wrap_ovf",   ovf_w,   x.o_w);
    check_eq("wrap_match", match_w, x.d_w == x.cmp);
    check_eq("wrap_zero",  zero_w,  x.d_w == 8'h00);
    check_eq("sat_d",      d_s,     x.d_s);
    check_eq("sat_ovf",    ovf_s,   x.o_s);
    check_eq("sat_match",  match_s, x.d_s == x.cmp);
    check_eq("sat_zero",   zero_s,  x.d_s == 8'h00);
  endtask

  initial begin
    arst = 1'b0; en = 1'b0; dir = 1'b1; pre = 1'b0; pval = 8'h00; cmp = 8'h00;
    m_dw = 8'h00; m_ds = 8'h00; m_ow = 1'b0; m_os = 1'b0;

    // Reset wins over preset and enable
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 8'h00);
      check_eq("rst_d_w", d_w, 8'h00);
      check_eq("rst_d_s", d_s, 8'h5A);
      check_eq("rst_ovf", {ovf_w, ovf_s}, 2'b00);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check_eq("rst_inc_w", d_w, 8'h01);
    check_eq("rst_inc_s", d_s, 8'h5B);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);

    // Wrap going up
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'hFE, 8'h00);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check_eq("wrap1_d", d_w, 8'hFF); check_eq("wrap1_o", ovf_w, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check_eq("wrap2_d", d_w, 8'h00); check_eq("wrap2_o", ovf_w, 1'b1);
    check_eq("clamp_up_d", d_s, 8'hFF); check_eq("clamp_up_o", ovf_s, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check_eq("wrap3_d", d_w, 8'h01); check_eq("wrap3_o", ovf_w, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);

    // Clamp going down, flag held across consecutive clamps
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    check_eq("sat1_d", d_s, 8'h00); check_eq("sat1_o", ovf_s, 1'b0);
    check_eq("sat1_z", zero_s, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      check_eq("satn_d", d_s, 8'h00); check_eq("satn_o", ovf_s, 1'b1);
    end

    // Preset beats enable and clears the flag
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h40, 8'h00);
    check_eq("pre_d", d_s, 8'h40); check_eq("pre_o", ovf_s, 1'b0);
    check_eq("pre_dw", d_w, 8'h40);

    // Match and direction reversal
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 8'h05);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h05);
    check_eq("m4", match_w, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h05);
    check_eq("m5_d", d_w, 8'h05); check_eq("m5", match_w, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h05);
    check_eq("rev_d", d_w, 8'h04); check_eq("rev_m", match_w, 1'b0);

    // Reset during a wrap step
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check_eq("rstw_d", d_w, 8'h00); check_eq("rstw_o", ovf_w, 1'b0);
    check_eq("rstw_ds", d_s, 8'h5A); check_eq("rstw_os", ovf_s, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    check_eq("rstw_hold_o", ovf_w, 1'b0);

    // Random traffic, biased toward long runs so both limits are reached
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 31) != 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 85 : 15)),
           ($urandom_range(0, 15) == 0),
           8'($urandom_range(0, 255)),
           8'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sync_updown_counter

// File: doc/sync_updown_counter.md
SYNC_UPDOWN_COUNTER -- requirements
Module: sync_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, counter and data width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, value loaded into D_o on reset (WIDTH bits).
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 = wrap-around, 1 = clamp at the limit.
REQ-004 Port CLK, input, 1: clock; all state updates occur on its rising edge only.
REQ-005 Port ARST, input, 1: reset; synchronous, active-low.
REQ-006 Port Enable_i, input, 1: count one step this cycle when high.
REQ-007 Port Direction_i, input, 1: 1 = count up, 0 = count down.
REQ-008 Port Preset_i, input, 1: load PresetVal_i this cycle when high.
REQ-009 Port PresetVal_i, input, WIDTH: preset value.
REQ-010 Port CompareVal_i, input, WIDTH: compare value for Match_o.
REQ-011 Port D_o, output, WIDTH: current counter value (registered).
REQ-012 Port Overflow_o, output, 1: registered one-cycle limit-event flag.
REQ-013 Port Match_o, output, 1: high when D_o == CompareVal_i.
REQ-014 Port Zero_o, output, 1: high when D_o == 0.

Function
REQ-015 Update priority per rising CLK edge SHALL be: ARST low > Preset_i > Enable_i > hold.
REQ-016 Preset_i high SHALL load D_o <= PresetVal_i next cycle, ignore Enable_i, and clear Overflow_o.
REQ-017 Enable_i high without Preset_i SHALL step D_o by +1 (Direction_i=1) or -1 (Direction_i=0), latency one cycle.
REQ-018 SATURATE=0: up from all-ones SHALL give 0; down from 0 SHALL give all-ones.
REQ-019 SATURATE=1: up at all-ones and down at 0 SHALL leave D_o unchanged.
REQ-020 Overflow_o SHALL be high for exactly the cycle after a step that wrapped (SATURATE=0) or was clamped (SATURATE=1), and low otherwise.
REQ-021 Consecutive clamped steps SHALL keep Overflow_o high for each following cycle.
REQ-022 Enable_i low with no preset SHALL hold D_o and drive Overflow_o low.
REQ-023 Match_o and Zero_o SHALL be combinational from D_o and CompareVal_i, with no additional register stage.
REQ-024 A Direction_i change between cycles SHALL take effect on the next enabled step, with no dead cycle.

Reset
REQ-025 ARST low at a rising CLK edge SHALL set D_o <= RESET_VALUE and Overflow_o <= 0 regardless of all other inputs.
REQ-026 ARST SHALL have no effect between clock edges; no asynchronous reset path SHALL exist in the block.
REQ-027 Reset asserted mid-count or during preset SHALL win; counting SHALL resume on the first edge with ARST high.

Structure
REQ-028 Package sync_counter_pkg SHALL hold the direction constants (DIR_UP=1, DIR_DOWN=0) and the mode constants (MODE_WRAP=0, MODE_SATURATE=1).
REQ-029 Next-value and limit-event logic SHALL reside in combinational sub-module counter_step (inputs: value, direction, mode; outputs: next value, event flag).
REQ-030 The top level SHALL contain only the D_o and Overflow_o registers, the priority mux, and the comparators.

Verification (WIDTH=8)
REQ-031 ARST=0 with Enable_i=1 and Preset_i=1 for 3 cycles -> D_o=RESET_VALUE and Overflow_o=0 throughout; with ARST=1 and Enable_i=1 up, D_o increments from RESET_VALUE starting on the next edge.
REQ-032 SATURATE=0: preset 0xFE, then 3 up steps -> D_o=0xFF, 0x00, 0x01; Overflow_o high only in the cycle D_o=0x00.
REQ-033 SATURATE=1: preset 0x01, then 4 down steps -> D_o=0x00, 0x00, 0x00, 0x00; Overflow_o high in the cycles following the 2nd, 3rd and 4th steps; Zero_o high from the first 0x00.
REQ-034 Preset_i=1 with PresetVal_i=0x40 and Enable_i=1 in the same cycle -> D_o=0x40, not 0x41; Overflow_o=0.
REQ-035 CompareVal_i=0x05, count up from 0x03 -> Match_o high only while D_o=0x05; flipping Direction_i there -> D_o returns to 0x04.
REQ-036 ARST pulsed low for one cycle during a wrap-around step -> D_o=RESET_VALUE and Overflow_o stays 0.
